// File: rtl/grid_renderer.sv
// Grid renderer: fetches each grid column word from RAM and plots it to the VGA
// adapter as 14 cells of 8x8 pixels, one pixel per clock.
module grid_renderer #(
  parameter int NUM_ROWS    = 16,
  parameter int RAM_LATENCY = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [27:0] ram_q,
  output logic [4:0]  ram_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RAM_LATENCY - 1);
  localparam logic [4:0]    ROW_LAST = 5'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW, FINISH} state_t;

  state_t         state_q, state_n;
  logic [4:0]     row_q, row_n;
  logic [LW-1:0]  lat_q, lat_n;
  logic [2:0]     px_q, px_n, py_q, py_n;
  logic [3:0]     j_q, j_n;
  logic [27:0]    shadow_q, shadow_n, word;
  logic [4:0]     addr_n;
  logic           done_n, plot_n;
  logic [7:0]     x_n;
  logic [6:0]     y_n;
  logic [2:0]     colour_n;

  // Cell value to RGB: bit0 of the cell drives red, bit1 drives green.
  function automatic logic [2:0] cell_colour(input logic [1:0] c);
    return {c[0], c[1], 1'b0};
  endfunction

  always_comb begin
    state_n  = state_q;
    row_n    = row_q;
    lat_n    = lat_q;
    px_n     = px_q;
    py_n     = py_q;
    j_n      = j_q;
    shadow_n = shadow_q;
    word     = shadow_q;
    addr_n   = ram_addr;
    done_n   = 1'b0;
    plot_n   = 1'b0;
    x_n      = vga_x;
    y_n      = vga_y;
    colour_n = vga_colour;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = FETCH;
          row_n   = '0;
          lat_n   = '0;
          addr_n  = '0;
        end
      end
      FETCH: begin
        if (lat_q == LAT_LAST) begin
          shadow_n = ram_q;
          word     = ram_q;
          state_n  = DRAW;
          px_n     = '0;
          py_n     = '0;
          j_n      = '0;
        end else begin
          lat_n = lat_q + 1'b1;
        end
      end
      DRAW: begin
        if (px_q == 3'd7 && py_q == 3'd7 && j_q == 4'd13) begin
          if (row_q < ROW_LAST) begin
            row_n   = row_q + 5'd1;
            addr_n  = row_q + 5'd1;
            lat_n   = '0;
            state_n = FETCH;
          end else begin
            state_n = FINISH;
            done_n  = 1'b1;
          end
        end else begin
          px_n = px_q + 3'd1;
          if (px_q == 3'd7) begin
            py_n = py_q + 3'd1;
            if (py_q == 3'd7) j_n = j_q + 4'd1;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Pixel outputs are registered, so they are built from next-cycle counters
    // to line up exactly with the DRAW cycles.
    if (state_n == DRAW) begin
      plot_n   = 1'b1;
      x_n      = {row_n, px_n};
      y_n      = {j_n, py_n};
      colour_n = cell_colour(word[{j_n, 1'b0} +: 2]);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      row_q      <= '0;
      lat_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      j_q        <= '0;
      shadow_q   <= '0;
      ram_addr   <= '0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      state_q    <= state_n;
      row_q      <= row_n;
      lat_q      <= lat_n;
      px_q       <= px_n;
      py_q       <= py_n;
      j_q        <= j_n;
      shadow_q   <= shadow_n;
      ram_addr   <= addr_n;
      done       <= done_n;
      vga_plot   <= plot_n;
      vga_x      <= x_n;
      vga_y      <= y_n;
      vga_colour <= colour_n;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: a small RAM model feeds frames and every
// plotted pixel is compared against coordinates/colours derived from the grid.
module tb_grid_renderer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [27:0] ram_q;
  logic [4:0]  ram_addr;
  logic        busy, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int errors = 0;

  logic [27:0] mem [32];
  logic [27:0] exp_mem [32];
  logic [4:0]  addr_d;

  int f_plots, f_dones, f_done_cyc, f_end, f_bad, f_red, f_yel, f_last_x, f_last_y;

  grid_renderer #(.NUM_ROWS(16), .RAM_LATENCY(2)) dut (
    .clock(clock), .resetn(resetn), .start(start), .ram_q(ram_q),
    .ram_addr(ram_addr), .busy(busy), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  // Two-cycle read RAM: registered address, then asynchronous read.
  always @(posedge clock) addr_d <= ram_addr;
  assign ram_q = mem[addr_d];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input logic [1:0] c);
    case (c)
      2'b00:   return 3'b000;
      2'b01:   return 3'b100;
      2'b10:   return 3'b010;
      default: return 3'b110;
    endcase
  endfunction

  // Pulses start, then walks the frame one cycle at a time (cycle 1 = first
  // FETCH cycle). start2_cyc re-asserts start; wr_cyc rewrites word 0.
  task automatic run_frame(input int start2_cyc, input int wr_cyc, input logic [27:0] wr_data);
    int cyc, row, j, px, py, ex, ey;
    logic [27:0] w;
    logic [2:0]  ec;
    f_plots = 0; f_dones = 0; f_done_cyc = -1; f_end = -1; f_bad = 0;
    f_red = 0; f_yel = 0; f_last_x = -1; f_last_y = -1;
    exp_mem = mem;
    start = 1'b1;
    @(negedge clock);
    cyc = 0;
    while (cyc < 20000) begin
      cyc++;
      if (vga_plot) begin
        row = f_plots / 896;
        j   = (f_plots % 896) / 64;
        py  = (f_plots / 8) % 8;
        px  = f_plots % 8;
        ex  = row * 8 + px;
        ey  = j * 8 + py;
        w   = exp_mem[row];
        ec  = exp_colour(w[2*j +: 2]);
        if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour !== ec) begin
          if (f_bad < 5)
            $display("FAIL pixel %0d: observed (%0d,%0d,%b) expected (%0d,%0d,%b)",
                     f_plots, vga_x, vga_y, vga_colour, ex, ey, ec);
          f_bad++;
        end
        if (vga_colour === 3'b100) f_red++;
        if (vga_colour === 3'b110) f_yel++;
        f_last_x = int'(vga_x);
        f_last_y = int'(vga_y);
        f_plots++;
      end else if (busy && !done && ram_addr !== 5'(f_plots / 896)) begin
        f_bad++;
      end
      if (ram_addr[4] !== 1'b0) f_bad++;
      if (done) begin
        f_dones++;
        f_done_cyc = cyc;
        if (vga_plot) f_bad++;
      end
      start = (cyc == start2_cyc);
      if (cyc == wr_cyc) mem[0] = wr_data;
      if (!busy) begin
        f_end = cyc;
        break;
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    start  = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    check("rst_addr", ram_addr, 0);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_no_start", busy, 0);

    // Black frame, with start re-pulsed mid-frame and during FINISH.
    run_frame(500, -1, '0);
    check("f1_plots", f_plots, 14336);
    check("f1_dones", f_dones, 1);
    check("f1_done_cyc", f_done_cyc, 14369);
    check("f1_end", f_end, 14370);
    check("f1_pixels", f_bad, 0);
    check("f1_colour_nz", f_red + f_yel, 0);
    run_frame(14369, -1, '0);
    check("f1b_done_cyc", f_done_cyc, 14369);
    repeat (3) @(negedge clock);
    check("finish_start_ignored", busy, 0);

    // Red cell in column 3, yellow last cell in column 15.
    mem[3]  = 28'h0000001;
    mem[15] = 28'hC000000;
    run_frame(-1, -1, '0);
    check("f2_plots", f_plots, 14336);
    check("f2_pixels", f_bad, 0);
    check("f2_red", f_red, 64);
    check("f2_yellow", f_yel, 64);
    check("f2_last_x", f_last_x, 127);
    check("f2_last_y", f_last_y, 111);
    check("f2_done_cyc", f_done_cyc, 14369);

    // Reset asserted for one cycle at frame cycle 5000.
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4999) @(negedge clock);
    check("mid_plot", vga_plot, 1);
    check("mid_busy", busy, 1);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    check("abort_plot", vga_plot, 0);
    check("abort_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done || busy || vga_plot) seen++;
    end
    check("abort_quiet", seen, 0);

    // Full frame after reset; word 0 rewritten during row 0 DRAW.
    for (int i = 0; i < 32; i++) mem[i] = '0;
    run_frame(-1, 100, 28'hFFFFFFF);
    check("f3_plots", f_plots, 14336);
    check("f3_pixels", f_bad, 0);
    check("f3_colour_nz", f_red + f_yel, 0);
    check("f3_dones", f_dones, 1);
    check("f3_end", f_end, 14370);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
